// File: rtl/gf4_inv_arbiter.sv
// gf4_inv_arbiter: one GF(2^4) inverter (field poly x^4+x+1) shared by
// NUM_REQ requesters. A round-robin grant picks one operand per cycle. The
// inverse lands in a single-entry output stage that is tagged with the
// requester ID. A full stage that is being popped can accept a new operand
// in the same cycle, so the unit sustains one result per cycle.
module gf4_inv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [3:0]           resp_data,
  output logic [3:0]           resp_operand
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;
  logic            grant_found;
  logic            space;
  logic            accept;
  logic [3:0]      grant_op;
  logic [3:0]      grant_inv;
  logic [3:0]      ops [NUM_REQ];

  // Multiplicative inverse in GF(2^4) mod x^4+x+1. Zero has no inverse,
  // so it is passed through as zero.
  function automatic logic [3:0] gf4_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h0;
      4'h1: y = 4'h1;
      4'h2: y = 4'h9;
      4'h3: y = 4'hE;
      4'h4: y = 4'hD;
      4'h5: y = 4'hB;
      4'h6: y = 4'h7;
      4'h7: y = 4'h6;
      4'h8: y = 4'hF;
      4'h9: y = 4'h2;
      4'hA: y = 4'hC;
      4'hB: y = 4'h5;
      4'hC: y = 4'hA;
      4'hD: y = 4'h4;
      4'hE: y = 4'h3;
      default: y = 4'h8;
    endcase
    return y;
  endfunction

  // Split the flat operand bus into per-requester nibbles.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
    assign ops[i] = req_data[4*i +: 4];
  end

  // Rotate-priority encoder: find the first valid requester starting at ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // The stage has room when it is empty or is being drained this cycle.
  always_comb begin
    space     = ~resp_valid | resp_ready;
    accept    = grant_found & space;
    grant_op  = ops[grant_idx];
    grant_inv = gf4_inv(grant_op);
    ptr_nxt   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

  // One-hot ready toward the granted requester only.
  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_idx] = space;
  end

  // Output stage and round-robin pointer. ptr advances only on an accept.
  // The data registers keep their last value after a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_data    <= '0;
      resp_operand <= '0;
    end else if (accept) begin
      ptr          <= ptr_nxt;
      resp_valid   <= 1'b1;
      resp_id      <= grant_idx;
      resp_data    <= grant_inv;
      resp_operand <= grant_op;
    end else if (resp_ready) begin
      resp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gf4_inv_arbiter.sv
// Testbench for gf4_inv_arbiter. It runs a table of directed vectors, an
// operand sweep, an asynchronous-reset case, and random traffic checked
// against a behavioural model. The model computes inverses by field search.
module tb_gf4_inv_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [3:0]  resp_data;
  logic [3:0]  resp_operand;

  int n_chk  = 0;
  int n_fail = 0;

  gf4_inv_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_operand (resp_operand)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [15:0] rd;
    logic        rr;
    logic [3:0]  ready;
    logic        v;
    logic [1:0]  id;
    logic [3:0]  dat;
    logic [3:0]  opd;
  } vec_t;

  vec_t tbl [15];

  // behavioural model state
  int       m_ptr;
  logic     m_valid;
  int       m_id;
  logic [3:0] m_dat, m_opd;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // carry-less multiply then reduce by x^4+x+1
  function automatic int gf_mul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 4; i++)
      if ((b >> i) & 1) p ^= a << i;
    for (int i = 6; i >= 4; i--)
      if ((p >> i) & 1) p ^= 'h13 << (i - 4);
    return p;
  endfunction

  function automatic int ref_inv(input int x);
    if (x == 0) return 0;
    for (int y = 1; y < 16; y++)
      if (gf_mul(x, y) == 1) return y;
    return -1;
  endfunction

  // Reset pulse placed between clock edges; also resets the model.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("reset_valid", int'(resp_valid), 0);
    reset = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_dat = 4'h0; m_opd = 4'h0;
  endtask

  // One model-checked cycle: check ready, clock, then check the stage.
  task automatic model_cycle(input logic [3:0] rv, input logic [15:0] rd, input logic rr);
    int g;
    int exp_ready;
    logic space;
    req_valid = rv; req_data = rd; resp_ready = rr;
    #1;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    space = !m_valid || rr;
    exp_ready = (g >= 0 && space) ? (1 << g) : 0;
    chk("rnd_ready", int'(req_ready), exp_ready);
    @(posedge clk); #1;
    if (g >= 0 && space) begin
      m_valid = 1'b1; m_id = g;
      m_opd = 4'((rd >> (4 * g)) & 'hF);
      m_dat = 4'(ref_inv(int'(m_opd)));
      m_ptr = (g + 1) % N;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    chk("rnd_valid", int'(resp_valid), int'(m_valid));
    if (m_valid) begin
      chk("rnd_id", int'(resp_id), m_id);
      chk("rnd_data", int'(resp_data), int'(m_dat));
      chk("rnd_opd", int'(resp_operand), int'(m_opd));
    end
  endtask

  initial begin
    // directed vectors: {rst, rv, rd, rr, ready, v, id, data, operand}
    tbl[0]  = '{1'b1, 4'b0001, 16'h0002, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h9, 4'h2};
    tbl[1]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h9, 4'h2};
    tbl[2]  = '{1'b1, 4'b1111, 16'hF843, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hE, 4'h3};
    tbl[3]  = '{1'b0, 4'b1111, 16'hF843, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hD, 4'h4};
    tbl[4]  = '{1'b0, 4'b1111, 16'hF843, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hF, 4'h8};
    tbl[5]  = '{1'b0, 4'b1111, 16'hF843, 1'b1, 4'b1000, 1'b1, 2'd3, 4'h8, 4'hF};
    tbl[6]  = '{1'b0, 4'b1111, 16'hF843, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hE, 4'h3};
    tbl[7]  = '{1'b1, 4'b0100, 16'h0A00, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC, 4'hA};
    tbl[8]  = '{1'b0, 4'b0010, 16'h0040, 1'b0, 4'b0000, 1'b1, 2'd2, 4'hC, 4'hA};
    tbl[9]  = '{1'b0, 4'b0010, 16'h0040, 1'b0, 4'b0000, 1'b1, 2'd2, 4'hC, 4'hA};
    tbl[10] = '{1'b0, 4'b0010, 16'h0040, 1'b0, 4'b0000, 1'b1, 2'd2, 4'hC, 4'hA};
    tbl[11] = '{1'b0, 4'b0010, 16'h0040, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hD, 4'h4};
    tbl[12] = '{1'b1, 4'b0010, 16'h0000, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h0, 4'h0};
    tbl[13] = '{1'b0, 4'b1001, 16'h6005, 1'b1, 4'b1000, 1'b1, 2'd3, 4'h7, 4'h6};
    tbl[14] = '{1'b0, 4'b1001, 16'h6005, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hB, 4'h5};

    reset = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", int'(resp_valid), 0);
    chk("rst_id", int'(resp_id), 0);
    chk("rst_data", int'(resp_data), 0);
    chk("rst_opd", int'(resp_operand), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      req_valid = tbl[i].rv; req_data = tbl[i].rd; resp_ready = tbl[i].rr;
      #1;
      chk($sformatf("vec%0d_ready", i), int'(req_ready), int'(tbl[i].ready));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), int'(resp_valid), int'(tbl[i].v));
      chk($sformatf("vec%0d_id", i), int'(resp_id), int'(tbl[i].id));
      chk($sformatf("vec%0d_data", i), int'(resp_data), int'(tbl[i].dat));
      chk($sformatf("vec%0d_opd", i), int'(resp_operand), int'(tbl[i].opd));
    end

    // operand sweep through requester 3; ptr wraps back to 0 every time
    do_reset();
    for (int x = 0; x < 16; x++) begin
      req_valid = 4'b1000; req_data = 16'(x << 12); resp_ready = 1'b1;
      #1;
      chk("sweep_ready", int'(req_ready), 'b1000);
      @(posedge clk); #1;
      chk("sweep_valid", int'(resp_valid), 1);
      chk("sweep_id", int'(resp_id), 3);
      chk($sformatf("sweep_inv_%0h", x), int'(resp_data), ref_inv(x));
      chk("sweep_opd", int'(resp_operand), x);
    end
    req_valid = 4'b1001; req_data = 16'h0000;
    #1;
    chk("sweep_ptr0", int'(req_ready), 'b0001);

    // asynchronous reset while a response is held
    do_reset();
    req_valid = 4'b0001; req_data = 16'h0002; resp_ready = 1'b0;
    @(posedge clk); #1;
    chk("areset_pre_valid", int'(resp_valid), 1);
    req_valid = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid_drop", int'(resp_valid), 0);
    reset = 1'b0;
    req_valid = 4'b0011; req_data = 16'h0021; resp_ready = 1'b1;
    #1;
    chk("areset_grant0", int'(req_ready), 'b0001);
    @(posedge clk); #1;
    chk("areset_id0", int'(resp_id), 0);
    chk("areset_data0", int'(resp_data), 1);
    #1;
    chk("areset_grant1", int'(req_ready), 'b0010);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++)
      model_cycle(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 3) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
